// File: rtl/alu_arbiter.sv
// Shares one ALU between NREQ requesters: round-robin grant, issue register, in-flight tag pipe, writeback and per-requester flags.
// Define ALU_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index-wins priority.
module alu_arbiter #(
   parameter int WIDTH       = 32,
   parameter int OPCODE      = 4,
   parameter int REGS_CODING = 3,
   parameter int FLAGS       = 4,
   parameter int CARRY       = 0,
   parameter int NREQ        = 4,
   parameter int IDW         = 2,
   parameter int ALU_LATENCY = 1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NREQ-1:0]             req_valid,
   input  logic [NREQ*OPCODE-1:0]      req_opcode,
   input  logic [NREQ*WIDTH-1:0]       req_op1,
   input  logic [NREQ*WIDTH-1:0]       req_op2,
   input  logic [NREQ*REGS_CODING-1:0] req_dest,
   output logic [NREQ-1:0]             req_grant,
   output logic                        alu_en,
   output logic [OPCODE-1:0]           alu_opcode,
   output logic [WIDTH-1:0]            alu_op1,
   output logic [WIDTH-1:0]            alu_op2,
   output logic [REGS_CODING-1:0]      alu_dest,
   output logic                        alu_cin,
   input  logic [WIDTH-1:0]            alu_result,
   input  logic [FLAGS-1:0]            alu_flags,
   input  logic [REGS_CODING-1:0]      alu_dest_out,
   input  logic [WIDTH-1:0]            alu_instr_addr,
   output logic                        wb_valid,
   output logic [IDW-1:0]              wb_id,
   output logic [REGS_CODING-1:0]      wb_dest,
   output logic [WIDTH-1:0]            wb_result,
   output logic [WIDTH-1:0]            wb_instr_addr,
   output logic [NREQ*FLAGS-1:0]       flags_out
);

   logic [NREQ-1:0]        busy;
   logic [NREQ-1:0]        eligible;
   logic [NREQ-1:0]        busy_clr;
   logic                   grant_any;
   logic [IDW-1:0]         grant_id;
   logic [IDW-1:0]         issue_id;
   logic                   tag_v  [ALU_LATENCY];
   logic [IDW-1:0]         tag_id [ALU_LATENCY];
   logic                   head_v;
   logic [IDW-1:0]         head_id;
   logic [FLAGS-1:0]       flags_reg [NREQ];
   logic [OPCODE-1:0]      opc_arr   [NREQ];
   logic [WIDTH-1:0]       op1_arr   [NREQ];
   logic [WIDTH-1:0]       op2_arr   [NREQ];
   logic [REGS_CODING-1:0] dest_arr  [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_lanes
      assign opc_arr[g]  = req_opcode[g*OPCODE +: OPCODE];
      assign op1_arr[g]  = req_op1[g*WIDTH +: WIDTH];
      assign op2_arr[g]  = req_op2[g*WIDTH +: WIDTH];
      assign dest_arr[g] = req_dest[g*REGS_CODING +: REGS_CODING];
      assign flags_out[g*FLAGS +: FLAGS] = flags_reg[g];
   end

   // A requester is locked out from its grant until the writeback of that op, so its carry-in is always settled.
   assign eligible = req_valid & ~busy;
   assign head_v   = tag_v[ALU_LATENCY-1];
   assign head_id  = tag_id[ALU_LATENCY-1];

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (eligible[IDW'(i)]) begin
            grant_any = 1'b1;
            grant_id  = IDW'(i);
         end
      end
   end
`else
   logic [IDW-1:0] ptr;
   int             idx;

   // Scan downward from the farthest offset so the nearest eligible requester at or after ptr wins.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      idx       = 0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) begin
            idx = idx - NREQ;
         end
         if (eligible[IDW'(idx)]) begin
            grant_any = 1'b1;
            grant_id  = IDW'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
      end
   end
`endif

   always_comb begin
      req_grant = '0;
      if (grant_any) begin
         req_grant[grant_id] = 1'b1;
      end
   end

   always_comb begin
      busy_clr = '0;
      if (head_v) begin
         busy_clr[head_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         alu_en     <= 1'b0;
         alu_opcode <= '0;
         alu_op1    <= '0;
         alu_op2    <= '0;
         alu_dest   <= '0;
         alu_cin    <= 1'b0;
         issue_id   <= '0;
      end else begin
         alu_en <= grant_any;
         if (grant_any) begin
            alu_opcode <= opc_arr[grant_id];
            alu_op1    <= op1_arr[grant_id];
            alu_op2    <= op2_arr[grant_id];
            alu_dest   <= dest_arr[grant_id];
            alu_cin    <= flags_reg[grant_id][CARRY];
            issue_id   <= grant_id;
         end
      end
   end

   // Tag pipe follows the issued op so its owner is known when the ALU output becomes valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < ALU_LATENCY; s++) begin
            tag_v[s]  <= 1'b0;
            tag_id[s] <= '0;
         end
      end else begin
         tag_v[0]  <= alu_en;
         tag_id[0] <= issue_id;
         for (int s = 1; s < ALU_LATENCY; s++) begin
            tag_v[s]  <= tag_v[s-1];
            tag_id[s] <= tag_id[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wb_valid      <= 1'b0;
         wb_id         <= '0;
         wb_dest       <= '0;
         wb_result     <= '0;
         wb_instr_addr <= '0;
         busy          <= '0;
         for (int r = 0; r < NREQ; r++) begin
            flags_reg[r] <= '0;
         end
      end else begin
         wb_valid <= head_v;
         busy     <= (busy & ~busy_clr) | req_grant;
         if (head_v) begin
            wb_id              <= head_id;
            wb_dest            <= alu_dest_out;
            wb_result          <= alu_result;
            wb_instr_addr      <= alu_instr_addr;
            flags_reg[head_id] <= alu_flags;
         end
      end
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between NREQ requesters (core execute stages) with round-robin arbitration.
- Registers the granted operation into the ALU issue stage and tracks in-flight ownership through the ALU latency.
- Writes results back to the owning requester and keeps a per-requester FLAGS register, which supplies the ALU carry-in.

Parameters:
- WIDTH, 32, operand/result width
- OPCODE, 4, opcode width
- REGS_CODING, 3, destination register code width
- FLAGS, 4, flag vector width
- CARRY, 0, bit index of carry in the flag vector
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester id width (clog2(NREQ))
- ALU_LATENCY, 1, cycles from alu_en high to ALU outputs valid (1..4)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NREQ  request pending, one bit per requester
- req_opcode  in  NREQ*OPCODE  packed opcodes; requester i at [i*OPCODE +: OPCODE]
- req_op1  in  NREQ*WIDTH  packed operand 1
- req_op2  in  NREQ*WIDTH  packed operand 2
- req_dest  in  NREQ*REGS_CODING  packed destination codes
- req_grant  out  NREQ  one-hot, combinational; accepts the request this cycle
- alu_en  out  1  to ALU en
- alu_opcode  out  OPCODE  to ALU opcode
- alu_op1  out  WIDTH  to ALU op1
- alu_op2  out  WIDTH  to ALU op2
- alu_dest  out  REGS_CODING  to ALU dest_in
- alu_cin  out  1  to ALU cin
- alu_result  in  WIDTH  from ALU result
- alu_flags  in  FLAGS  from ALU flags
- alu_dest_out  in  REGS_CODING  from ALU dest_out
- alu_instr_addr  in  WIDTH  from ALU instr_addr
- wb_valid  out  1  registered writeback strobe
- wb_id  out  IDW  owning requester
- wb_dest  out  REGS_CODING  destination register
- wb_result  out  WIDTH  result
- wb_instr_addr  out  WIDTH  ALU instr_addr passthrough
- flags_out  out  NREQ*FLAGS  per-requester flag registers

Behaviour:
- Reset, synchronous: all outputs 0, all flag registers 0, round-robin pointer 0, busy mask 0, tag pipe cleared.
  - Ops in flight at reset are discarded: no wb_valid after reset, even if the ALU later produces output.
- Eligibility: eligible[i] = req_valid[i] & ~busy[i].
  - busy[i] sets on grant to i and clears in the cycle wb_valid asserts for i.
  - At most one op per requester is in flight, so carry chaining is always correct.
- Arbitration: combinational.
  - Search eligible from pointer ptr upward, wrapping modulo NREQ; the first hit is granted.
  - Only one grant per cycle. No eligible requester means req_grant = 0.
  - On grant to i: ptr <= (i+1) mod NREQ. ptr is unchanged when there is no grant.
  - A requester must hold all req_* fields stable while req_valid is high and not granted.
  - It must drop req_valid (or present a new op) in the cycle after grant.
- Issue stage, at the edge ending grant cycle T:
  - Register opcode/op1/op2/dest of the granted requester.
  - alu_cin <= flags_reg[i][CARRY].
  - alu_en <= 1; push id into the tag pipe.
  - alu_en = 0 in any cycle following a no-grant cycle; alu_* data holds its last value.
- Tag pipe: ALU_LATENCY stages of {valid, id}, aligned with ALU output validity (T+1+ALU_LATENCY).
- Writeback, registered at the edge where tag-pipe head is valid:
  - wb_valid <= 1; wb_id <= id; wb_dest <= alu_dest_out; wb_result <= alu_result; wb_instr_addr <= alu_instr_addr.
  - flags_reg[id] <= alu_flags; busy[id] <= 0.
  - Otherwise wb_valid <= 0 and the other wb_* fields hold.
- Latency: grant in cycle T gives wb_valid high in cycle T+2+ALU_LATENCY (default T+3).
- Throughput: one op per cycle across requesters.
  - A single requester can issue at most once per ALU_LATENCY+2 cycles; after wb in cycle W it becomes eligible in cycle W.
- Simultaneous events: a busy clear and a new grant to the same requester may occur in the same cycle.
  - Grant uses the cleared busy bit (combinational from the wb_valid condition).
  - The new op's cin uses the just-written flags (forwarded from alu_flags).
- No writeback backpressure: wb consumers must accept every strobe.

Optional Feature:
- Macro ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index eligible requester wins and ptr is not implemented.
- Undefined (default): round-robin as above. All other behaviour is identical.

Test Plan:
- Single op: req_valid=0001, opcode ADD, op1=5, op2=7, cycle 1 -> req_grant=0001 in cycle 1; alu_en=1 cycle 2; wb_valid=1, wb_id=0, wb_result=12 in cycle 4.
- Fairness: all four requesters valid continuously, each op pending until granted (one op per requester) -> grants 0001,0010,0100,1000 in consecutive cycles; no requester regranted before its wb.
- Carry chain: requester 2 issues ADD 0xFFFFFFFF+1, then ADC 0+0 -> first wb flags CARRY=1, second wb_result=1; second grant occurs no earlier than first wb cycle.
- Busy lockout: requester 1 holds req_valid constantly -> grants to 1 spaced exactly 3 cycles apart (ALU_LATENCY=1).
- Reset mid-flight: grant in cycle 1, reset high in cycle 2 -> no wb_valid in cycles 3..6; flags_out=0; next grant starts from requester 0.
- Fixed priority build: ALU_ARB_FIXED_PRIO_EN defined, requesters 0 and 3 valid continuously -> 0 granted whenever eligible; 3 granted only in cycles where 0 is busy.
